// File: rtl/pulse_edge_generator.sv
`timescale 1ns/1ps
// Pulse edge generator: each accepted request yields one registered high pulse
// of programmable width followed by a guaranteed low gap. Optional one-deep
// request slot is built when PULSE_EDGE_GEN_QUEUE_EN is defined.
module pulse_edge_generator #(
  parameter int WIDTH_W = 8,
  parameter int MIN_LOW = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH_W-1:0] width,
  output logic               ready,
  output logic               pulse,
  output logic               done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [WIDTH_W-1:0] CNT_ONE  = WIDTH_W'(1);
  localparam logic [WIDTH_W-1:0] LOW_LOAD = WIDTH_W'(MIN_LOW - 1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH_W-1:0] cnt_q, cnt_d;
  logic               pulse_q, pulse_d;
  logic               done_q, done_d;
  logic               accept;
  logic               cnt_zero;
  logic [WIDTH_W-1:0] load_cnt;

  // Counter holds remaining cycles minus one, so width==0 and width==1 both load zero
  // and the full-scale width never needs an extra counter bit.
  assign load_cnt = (width == '0) ? '0 : width - CNT_ONE;
  assign cnt_zero = (cnt_q == '0);
  assign accept   = start && ready;

`ifdef PULSE_EDGE_GEN_QUEUE_EN
  logic               pend_valid_q, pend_valid_d;
  logic [WIDTH_W-1:0] pend_cnt_q, pend_cnt_d;

  assign ready = !pend_valid_q;
`else
  assign ready = (state_q == ST_IDLE);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef PULSE_EDGE_GEN_QUEUE_EN
    pend_valid_d = pend_valid_q;
    pend_cnt_d   = pend_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_HIGH;
          cnt_d   = load_cnt;
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          state_d = ST_LOW;
          cnt_d   = LOW_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
`ifdef PULSE_EDGE_GEN_QUEUE_EN
        if (accept) begin
          pend_valid_d = 1'b1;
          pend_cnt_d   = load_cnt;
        end
`endif
      end
      ST_LOW: begin
        if (cnt_zero) begin
          done_d = 1'b1;
`ifdef PULSE_EDGE_GEN_QUEUE_EN
          // Chain straight into the next pulse; the low gap has already been served.
          if (pend_valid_q) begin
            state_d      = ST_HIGH;
            cnt_d        = pend_cnt_q;
            pend_valid_d = 1'b0;
          end else if (accept) begin
            state_d = ST_HIGH;
            cnt_d   = load_cnt;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
`ifdef PULSE_EDGE_GEN_QUEUE_EN
          if (accept) begin
            pend_valid_d = 1'b1;
            pend_cnt_d   = load_cnt;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    pulse_d = (state_d == ST_HIGH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef PULSE_EDGE_GEN_QUEUE_EN
      pend_valid_q <= 1'b0;
      pend_cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
`ifdef PULSE_EDGE_GEN_QUEUE_EN
      pend_valid_q <= pend_valid_d;
      pend_cnt_q   <= pend_cnt_d;
`endif
    end
  end

  assign pulse = pulse_q;
  assign done  = done_q;

endmodule

// File: tb/tb_pulse_edge_generator.sv
`timescale 1ns/1ps
// Bench for pulse_edge_generator: directed and random requests compared cycle by
// cycle against a timeline model of when each accepted pulse starts and ends.
module tb_pulse_edge_generator;

  localparam int WW   = 8;
  localparam int ML   = 2;
  localparam int NCYC = 40000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [WW-1:0] width = '0;
  logic          ready, pulse, done;

  pulse_edge_generator #(.WIDTH_W(WW), .MIN_LOW(ML)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .width (width),
    .ready (ready),
    .pulse (pulse),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected waveform timeline, indexed by cycle number.
  bit exp_pulse [NCYC];
  bit exp_done  [NCYC];
  int cyc      = 0;
  int last_hs  = 0;   // first high cycle of the most recent accepted request
  int last_end = 0;   // its completion (done) cycle
  int n_accept = 0;
  bit armed    = 1'b0;

  int dut_rises = 0, exp_rises = 0, dut_dones = 0, exp_dones = 0;
  bit prev_pulse = 1'b0, prev_exp = 1'b0, seen_pulse = 1'b0;
  int low_run = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
  endtask

  function automatic bit model_ready(input int c);
`ifdef PULSE_EDGE_GEN_QUEUE_EN
    return !(last_hs > c);
`else
    return c >= last_end;
`endif
  endfunction

  // One clock cycle: drive inputs, check this cycle's outputs, then advance the model
  // across the edge that closes the cycle.
  task automatic step(input bit r, input bit s, input logic [WW-1:0] w);
    int we;
    int hs;
    int lim;
    @(posedge clk);
    #1;
    rst   = r;
    start = s;
    width = w;
    @(negedge clk);
    if (armed) begin
      check_eq("pulse", 32'(pulse), 32'(exp_pulse[cyc]));
      check_eq("done",  32'(done),  32'(exp_done[cyc]));
      check_eq("ready", 32'(ready), 32'(model_ready(cyc)));
      if (exp_pulse[cyc] && !prev_exp) exp_rises++;
      if (exp_done[cyc]) exp_dones++;
      if (done === 1'b1) dut_dones++;
      if (pulse === 1'b1) begin
        if (!prev_pulse) begin
          dut_rises++;
          if (seen_pulse) check_eq("low_gap", 32'(low_run >= ML), 32'd1);
        end
        seen_pulse = 1'b1;
        low_run    = 0;
      end else begin
        low_run++;
      end
      prev_pulse = (pulse === 1'b1);
      prev_exp   = exp_pulse[cyc];
    end
    if (r) begin
      armed = 1'b1;
      lim   = (cyc + 600 < NCYC) ? cyc + 600 : NCYC - 1;
      for (int k = cyc + 1; k <= lim; k++) begin
        exp_pulse[k] = 1'b0;
        exp_done[k]  = 1'b0;
      end
      last_hs    = cyc + 1;
      last_end   = cyc + 1;
      seen_pulse = 1'b0;
    end else if (s && armed && model_ready(cyc)) begin
      we = (w == '0) ? 1 : int'(w);
      hs = (cyc + 1 > last_end) ? cyc + 1 : last_end;
      for (int k = hs; k < hs + we; k++) if (k < NCYC) exp_pulse[k] = 1'b1;
      if (hs + we + ML < NCYC) exp_done[hs + we + ML] = 1'b1;
      last_hs  = hs;
      last_end = hs + we + ML;
      n_accept++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, WW'($urandom_range(0, 255)));
  endtask

  initial begin
    int target;
    int budget;

    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);

    // single request, width 3
    step(1'b0, 1'b1, 8'd3);
    idle(8);

    // width 0 behaves as 1
    step(1'b0, 1'b1, 8'd0);
    idle(6);

    // full-scale width must not wrap
    step(1'b0, 1'b1, 8'd255);
    idle(262);

    // start held high continuously
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'd2);
    idle(12);

    // extra starts during HIGH and LOW
    step(1'b0, 1'b1, 8'd4);
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 8'd7);
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 8'd6);
    step(1'b0, 1'b1, 8'd3);
    idle(25);

    // reset in the second high cycle of a width-5 pulse, then immediate restart
    step(1'b0, 1'b1, 8'd5);
    step(1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b1, 8'd5);
    idle(12);

    // random requests
    target = n_accept + 1000;
    budget = 0;
    while (n_accept < target && budget < 30000) begin
      step(1'b0, ($urandom_range(0, 2) == 0), WW'($urandom_range(0, 20)));
      budget++;
    end
    check_eq("rand_budget", 32'(n_accept >= target), 32'd1);
    idle(30);

    check_eq("rise_count", 32'(dut_rises), 32'(exp_rises));
    check_eq("done_count", 32'(dut_dones), 32'(exp_dones));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_edge_generator.md
Name: pulse_edge_generator

Overview:
- Transmit-side counterpart of the team's rising-edge detector.
- Converts a one-cycle request into a clean, registered high pulse of programmable width on `pulse`, followed by a guaranteed minimum low gap.
- A downstream edge detector sampling `pulse` on the same clock therefore sees exactly one rising edge per accepted request.
- Used to drive strobe and handshake lines that are consumed by edge detectors elsewhere in the design.

Parameters:
- WIDTH_W, 8: width of the `width` input and the internal counter.
- MIN_LOW, 1: minimum number of low cycles after each pulse. Must be >=1 and <= 2**WIDTH_W.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse request; accepted on a clock edge where start && ready.
- width  input  WIDTH_W  high time in cycles; latched on acceptance; 0 treated as 1.
- ready  output  1  block can accept a request this cycle.
- pulse  output  1  registered generated pulse (state==HIGH).
- done  output  1  one-cycle registered strobe marking completion of a pulse plus its low gap.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values (rst sampled high on an edge): state=IDLE, pulse=0, done=0, ready=1, counter=0, pending slot (if built) cleared.
  - Reset mid-pulse forces `pulse` low on the next cycle. There is no completion `done` for the aborted request.
- FSM states: IDLE, HIGH, LOW.
- IDLE: ready=1, pulse=0.
  - On accept: w_eff = (width==0) ? 1 : width; cnt <= w_eff-1; next state HIGH.
- HIGH: pulse=1, ready=0.
  - If cnt==0: cnt <= MIN_LOW-1; go to LOW.
  - Else: cnt <= cnt-1.
- LOW: pulse=0, ready=0.
  - If cnt==0: go to IDLE and set done <= 1.
  - Else: cnt <= cnt-1.
- done is high for exactly one cycle: the first cycle after LOW ends. It is 0 in all other cycles.
- Latency and timing: accept at edge E.
  - pulse=1 for cycles E+1 .. E+w_eff.
  - pulse=0 for the next MIN_LOW cycles.
  - done=1 and ready=1 in cycle E+w_eff+MIN_LOW+1.
- Back-to-back: a start held high through the done cycle is accepted on that edge. Minimum rising-edge spacing is w_eff+MIN_LOW+1 cycles (base build).
- start while ready=0 is ignored (no effect, no error). width is ignored when not accepted.
- width=2**WIDTH_W-1 must produce exactly that many high cycles; the counter must not wrap.
- done and start in the same cycle: handled as a normal IDLE accept.

Optional Feature:
- Macro: PULSE_EDGE_GEN_QUEUE_EN.
- Without the macro: behaviour exactly as above; ready=(state==IDLE).
- With the macro, a one-deep pending slot (pend_valid, pend_width) is added:
  - ready = !pend_valid in all states.
  - Accept in IDLE goes straight to HIGH and does not use the slot.
  - Accept in HIGH or LOW stores w_eff in the slot.
  - Accept on the final LOW edge with an empty slot is not stored; the FSM loads it directly into HIGH.
  - When LOW finishes with pend_valid=1 or a simultaneous accept: the FSM goes directly to HIGH (no IDLE cycle) with cnt <= width-1, pend_valid clears, and done=1 in that first HIGH cycle.
  - Resulting rising-edge spacing is w_eff+MIN_LOW.
  - The MIN_LOW gap is never shortened.
  - Reset clears the slot.

Test Plan:
- Reset then single request: rst 2 cycles, start=1 with width=3 for 1 cycle, MIN_LOW=2 -> pulse high exactly 3 cycles, low 2, then done=1 for 1 cycle with ready=1; the attached edge detector fires exactly once.
- width=0 -> pulse high exactly 1 cycle. width=255 (WIDTH_W=8) -> exactly 255 high cycles, no wrap.
- start held high continuously, width=2, MIN_LOW=1 -> base build: rising edges every 4 cycles, done every 4 cycles. Queue build: rising edges every 3 cycles, and pulse never low for fewer than 1 cycle between pulses.
- start pulsed during HIGH and during LOW (base build) -> ignored, exactly one pulse generated. Same stimulus with the queue build -> the first extra start is queued and a second pulse follows; any further start while pend_valid=1 is ignored.
- rst asserted in the 2nd high cycle of a width=5 pulse -> pulse=0, ready=1, done=0 on the next cycle. A new start accepted immediately after rst deasserts produces a full 5-cycle pulse.
- Randomized widths 0..20 over 1000 requests -> edge-detector count equals accepted-request count, done count equals completed-pulse count, and every low gap is >= MIN_LOW.
